// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
//   ONE        : unity twiddle, 2^(TW-2) at the default twiddle width
//   cplx_t     : complex sample at the default data width
//   sat_round  : round-half-up by k bits, then clamp to a signed dw-bit range;
//                returns the clamped value (sign-extended to RW) and a clamp flag
package fft_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned TW_DEF = 16;
  localparam int unsigned ONE    = 1 << (TW_DEF - 2);
  // Widest intermediate sat_round accepts; callers keep DW+TW+3 within this.
  localparam int unsigned RW     = 64;

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [RW-1:0] val;
    logic                 sat;
  } sat_res_t;

  function automatic sat_res_t sat_round(input logic signed [RW-1:0] x,
                                         input int unsigned k,
                                         input int unsigned dw);
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] hi;
    logic signed [RW-1:0] lo;
    sat_res_t res;
    half = (k == 0) ? '0 : (RW'(1) << (k - 1));
    r    = (x + half) >>> k;
    hi   = (RW'(1) <<< (dw - 1)) - RW'(1);
    lo   = -(RW'(1) <<< (dw - 1));
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmult_pipe.sv
// Pipelined complex multiply B*W (or B*conj(W)), full precision.
//   clk, rst (async high), ce : clock, reset, clock enable
//   br, bi                    : multiplicand, DW signed
//   wr, wi                    : twiddle, TW signed Q2.(TW-2)
//   inv                       : 1 = multiply by conj(W)
//   pr, pi                    : product, DW+TW+2 signed, valid two enabled
//                               cycles after the operands (combined from S2 regs)
module cmult_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic signed [DW-1:0]   br,
  input  logic signed [DW-1:0]   bi,
  input  logic signed [TW-1:0]   wr,
  input  logic signed [TW-1:0]   wi,
  input  logic                   inv,
  output logic signed [DW+TW+1:0] pr,
  output logic signed [DW+TW+1:0] pi
);

  localparam int unsigned MW = DW + TW + 1;
  localparam int unsigned PW = DW + TW + 2;

  logic signed [DW-1:0] b1r, b1i;
  logic signed [TW-1:0] w1r, w1i;
  logic                 inv1;
  logic signed [TW:0]   wi_ext, wi_eff;
  logic signed [MW-1:0] p_rr, p_ii, p_ri, p_ir;

  // Negating at TW+1 bits keeps -(-2^(TW-1)) representable.
  assign wi_ext = (TW+1)'(w1i);
  assign wi_eff = inv1 ? -wi_ext : wi_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1r  <= '0;
      b1i  <= '0;
      w1r  <= '0;
      w1i  <= '0;
      inv1 <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
    end else if (ce) begin
      b1r  <= br;
      b1i  <= bi;
      w1r  <= wr;
      w1i  <= wi;
      inv1 <= inv;
      p_rr <= MW'(b1r) * MW'(w1r);
      p_ii <= MW'(b1i) * MW'(wi_eff);
      p_ri <= MW'(b1r) * MW'(wi_eff);
      p_ir <= MW'(b1i) * MW'(w1r);
    end
  end

  assign pr = PW'(p_rr) - PW'(p_ii);
  assign pi = PW'(p_ri) + PW'(p_ir);

endmodule

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly X = A + B*W, Y = A - B*W, four-stage valid pipeline.
//   clk, rst (async high), ce          : clock, reset, global clock enable
//   in_valid, ar/ai, br/bi, wr/wi      : sample qualifier, operands, twiddle
//   inv, scale_sh                      : per-sample conj(W) select and right shift
//   out_valid, xr/xi, yr/yi            : result qualifier and results
//   out_sat                            : this output sample clamped somewhere
//   ovf_sticky, ovf_clr                : sticky overflow flag and its clear
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DW  = 16,
  parameter int unsigned TW  = 16,
  parameter int unsigned SHW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] ar,
  input  logic signed [DW-1:0] ai,
  input  logic signed [DW-1:0] br,
  input  logic signed [DW-1:0] bi,
  input  logic signed [TW-1:0] wr,
  input  logic signed [TW-1:0] wi,
  input  logic                 inv,
  input  logic [SHW-1:0]       scale_sh,
  output logic                 out_valid,
  output logic [DW-1:0]        xr,
  output logic [DW-1:0]        xi,
  output logic [DW-1:0]        yr,
  output logic [DW-1:0]        yi,
  output logic                 out_sat,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  localparam int unsigned PW = DW + TW + 2;
  localparam int unsigned SW = DW + TW + 3;

  logic signed [DW-1:0]  a1r, a1i, a2r, a2i;
  logic [SHW-1:0]        sh1, sh2, sh3;
  logic                  v1, v2, v3;
  logic signed [PW-1:0]  pr, pi;
  logic signed [SW-1:0]  alr, ali;
  logic signed [SW-1:0]  sxr, sxi, syr, syi;
  sat_res_t              rxr, rxi, ryr, ryi;
  int unsigned           k;
  logic                  any_sat;
  logic                  unused_hi;

  cmult_pipe #(
    .DW(DW),
    .TW(TW)
  ) u_cmult (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .br (br),
    .bi (bi),
    .wr (wr),
    .wi (wi),
    .inv(inv),
    .pr (pr),
    .pi (pi)
  );

  // A scaled into the product's Q(TW-2) domain.
  assign alr = SW'(a2r) <<< (TW - 2);
  assign ali = SW'(a2i) <<< (TW - 2);

  always_comb begin
    k       = (TW - 2) + 32'(sh3);
    rxr     = sat_round(RW'(sxr), k, DW);
    rxi     = sat_round(RW'(sxi), k, DW);
    ryr     = sat_round(RW'(syr), k, DW);
    ryi     = sat_round(RW'(syi), k, DW);
    any_sat = rxr.sat | rxi.sat | ryr.sat | ryi.sat;
  end

  // Upper bits are pure sign extension once clamped.
  assign unused_hi = ^{rxr.val[RW-1:DW], rxi.val[RW-1:DW],
                       ryr.val[RW-1:DW], ryi.val[RW-1:DW]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1r <= '0;
      a1i <= '0;
      a2r <= '0;
      a2i <= '0;
      sh1 <= '0;
      sh2 <= '0;
      sh3 <= '0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      sxr <= '0;
      sxi <= '0;
      syr <= '0;
      syi <= '0;
    end else if (ce) begin
      a1r <= ar;
      a1i <= ai;
      sh1 <= scale_sh;
      v1  <= in_valid;
      a2r <= a1r;
      a2i <= a1i;
      sh2 <= sh1;
      v2  <= v1;
      sxr <= alr + SW'(pr);
      sxi <= ali + SW'(pi);
      syr <= alr - SW'(pr);
      syi <= ali - SW'(pi);
      sh3 <= sh2;
      v3  <= v2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      xr         <= '0;
      xi         <= '0;
      yr         <= '0;
      yi         <= '0;
      out_sat    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (ce) begin
      out_valid <= v3;
      xr        <= rxr.val[DW-1:0];
      xi        <= rxi.val[DW-1:0];
      yr        <= ryr.val[DW-1:0];
      yi        <= ryi.val[DW-1:0];
      out_sat   <= v3 & any_sat;
      // A saturating sample entering or currently on the outputs beats a clear.
      if ((v3 & any_sat) | out_sat)
        ovf_sticky <= 1'b1;
      else if (ovf_clr)
        ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed and random checks for butterfly_pipe at DW=16, TW=16.
module tb_butterfly_pipe;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic        inv = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] ar = '0, ai = '0, br = '0, bi = '0, wr = '0, wi = '0;
  logic [1:0]  scale_sh = '0;
  logic        out_valid, out_sat, ovf_sticky;
  logic [15:0] xr, xi, yr, yi;

  always #5 clk = ~clk;

  butterfly_pipe #(
    .DW (16),
    .TW (16),
    .SHW(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .ar        (ar),
    .ai        (ai),
    .br        (br),
    .bi        (bi),
    .wr        (wr),
    .wi        (wi),
    .inv       (inv),
    .scale_sh  (scale_sh),
    .out_valid (out_valid),
    .xr        (xr),
    .xi        (xi),
    .yr        (yr),
    .yi        (yi),
    .out_sat   (out_sat),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    cplx_t x;
    cplx_t y;
    logic  sat;
    int    en;
    string tag;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   en_cnt = 0;
  bit   ce_at_edge = 1'b0;
  bit   rand_ce = 1'b0;

  localparam logic [15:0] W_ONE = 16'(ONE);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts enabled edges so output latency can be measured in enabled cycles.
  always @(posedge clk) begin
    ce_at_edge <= ce && !rst;
    if (ce && !rst) en_cnt <= en_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst && ce_at_edge && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", out_valid, 0);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.tag, ".xr"}, xr, $unsigned(mon_e.x.re));
        check({mon_e.tag, ".xi"}, xi, $unsigned(mon_e.x.im));
        check({mon_e.tag, ".yr"}, yr, $unsigned(mon_e.y.re));
        check({mon_e.tag, ".yi"}, yi, $unsigned(mon_e.y.im));
        check({mon_e.tag, ".sat"}, out_sat, mon_e.sat);
        check({mon_e.tag, ".lat"}, en_cnt - mon_e.en, 3);
      end
    end
  end

  task automatic send(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
                      input logic iv, input logic [1:0] sh,
                      input logic [15:0] e_xr, e_xi, e_yr, e_yi,
                      input logic e_sat, input string tag, input bit push);
    exp_t e;
    ar = a_r; ai = a_i; br = b_r; bi = b_i; wr = w_r; wi = w_i;
    inv = iv; scale_sh = sh; in_valid = 1'b1;
    do begin
      ce = rand_ce ? ($urandom_range(3) != 0) : 1'b1;
      @(posedge clk); #1;
    end while (!ce);
    in_valid = 1'b0;
    if (push) begin
      e.x.re = e_xr; e.x.im = e_xi; e.y.re = e_yr; e.y.im = e_yi;
      e.sat = e_sat; e.en = en_cnt; e.tag = tag;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    ce = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [15:0] rs(input longint s, input int k, inout logic sat);
    longint r;
    r = (s + (longint'(1) <<< (k - 1))) >>> k;
    if (r > 32767) begin sat = 1'b1; return 16'h7fff; end
    if (r < -32768) begin sat = 1'b1; return 16'h8000; end
    return r[15:0];
  endfunction

  task automatic send_rand(input int n);
    logic [15:0] v_ar, v_ai, v_br, v_bi, v_wr, v_wi, e0, e1, e2, e3;
    logic [1:0]  v_sh;
    logic        v_inv, s;
    longint      a_r, a_i, b_r, b_i, w_r, w_i, pr, pi;
    int          k;
    v_ar = 16'($urandom); v_ai = 16'($urandom);
    v_br = 16'($urandom); v_bi = 16'($urandom);
    v_wr = 16'($urandom); v_wi = 16'($urandom);
    v_sh = 2'($urandom); v_inv = 1'($urandom);
    a_r = longint'($signed(v_ar)); a_i = longint'($signed(v_ai));
    b_r = longint'($signed(v_br)); b_i = longint'($signed(v_bi));
    w_r = longint'($signed(v_wr)); w_i = longint'($signed(v_wi));
    if (v_inv) w_i = -w_i;
    pr = b_r * w_r - b_i * w_i;
    pi = b_r * w_i + b_i * w_r;
    k = 14 + int'(v_sh);
    s = 1'b0;
    e0 = rs(a_r * longint'(ONE) + pr, k, s);
    e1 = rs(a_i * longint'(ONE) + pi, k, s);
    e2 = rs(a_r * longint'(ONE) - pr, k, s);
    e3 = rs(a_i * longint'(ONE) - pi, k, s);
    send(v_ar, v_ai, v_br, v_bi, v_wr, v_wi, v_inv, v_sh, e0, e1, e2, e3, s,
         $sformatf("rnd%0d", n), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.xr", xr, 0);
    check("rst.yi", yi, 0);
    check("rst.out_sat", out_sat, 0);
    check("rst.sticky", ovf_sticky, 0);
    rst = 1'b0;
    idle(2);

    // Unity twiddle, -j, inverse
    send(16'd100, 16'd50, 16'd20, 16'(-10), W_ONE, 16'd0, 1'b0, 2'd0,
         16'd120, 16'd40, 16'd80, 16'd60, 1'b0, "unity", 1'b1);
    send(16'd100, 16'd50, 16'd20, 16'(-10), 16'd0, 16'hC000, 1'b0, 2'd0,
         16'd90, 16'd30, 16'd110, 16'd70, 1'b0, "minus_j", 1'b1);
    send(16'd100, 16'd50, 16'd20, 16'(-10), 16'd0, 16'hC000, 1'b1, 2'd0,
         16'd110, 16'd70, 16'd90, 16'd30, 1'b0, "minus_j_inv", 1'b1);
    // Rounding and back-to-back per-sample scale
    send(16'd3, 16'(-3), 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd1,
         16'd2, 16'(-1), 16'd2, 16'(-1), 1'b0, "rnd_3", 1'b1);
    send(16'd1, 16'(-1), 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd1,
         16'd1, 16'd0, 16'd1, 16'd0, 1'b0, "rnd_1", 1'b1);
    send(16'd100, 16'(-100), 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd0,
         16'd100, 16'(-100), 16'd100, 16'(-100), 1'b0, "sh0", 1'b1);
    send(16'd100, 16'(-100), 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd2,
         16'd25, 16'(-25), 16'd25, 16'(-25), 1'b0, "sh2", 1'b1);
    send(16'd100, 16'(-100), 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd3,
         16'd13, 16'(-12), 16'd13, 16'(-12), 1'b0, "sh3", 1'b1);
    send(16'd100, 16'(-100), 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd1,
         16'd50, 16'(-50), 16'd50, 16'(-50), 1'b0, "sh1", 1'b1);
    idle(6);
    check("pre_sat.sticky", ovf_sticky, 0);

    // Saturation and sticky flag
    send(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, W_ONE, 16'd0, 1'b0, 2'd0,
         16'h7FFF, 16'd0, 16'd0, 16'd0, 1'b1, "sat_sh0", 1'b1);
    idle(4);
    check("sat.sticky_set", ovf_sticky, 1);
    idle(3);
    check("sat.sticky_hold", ovf_sticky, 1);
    send(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, W_ONE, 16'd0, 1'b0, 2'd1,
         16'd32767, 16'd0, 16'd0, 16'd0, 1'b0, "sat_sh1", 1'b1);
    idle(4);
    check("sat_sh1.sticky_hold", ovf_sticky, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("clr.sticky", ovf_sticky, 0);
    send(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, W_ONE, 16'd0, 1'b0, 2'd0,
         16'h7FFF, 16'd0, 16'd0, 16'd0, 1'b1, "sat_coin", 1'b1);
    idle(3);
    check("coin.out_sat", out_sat, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("coin.sticky_wins", ovf_sticky, 1);
    idle(1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("coin.clr_after", ovf_sticky, 0);
    idle(4);

    // Stall: 8 samples with ce low for 3 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        ar = 16'h1234; in_valid = 1'b1; ce = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
        end
        in_valid = 1'b0; ce = 1'b1;
      end
      send(16'(10 * (i + 1)), 16'(-(i + 1)), 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd0,
           16'(10 * (i + 1)), 16'(-(i + 1)), 16'(10 * (i + 1)), 16'(-(i + 1)), 1'b0,
           $sformatf("stall%0d", i), 1'b1);
    end
    idle(6);
    check("stall.drained", q.size(), 0);

    // Reset with three samples in flight
    for (int i = 0; i < 7; i++)
      send(16'(i + 1), 16'd0, 16'd0, 16'd0, W_ONE, 16'd0, 1'b0, 2'd0,
           16'(i + 1), 16'd0, 16'(i + 1), 16'd0, 1'b0,
           $sformatf("pre_rst%0d", i), i < 4);
    @(negedge clk); #1;
    check("pre_rst.out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst.out_valid", out_valid, 0);
    check("mid_rst.xr", xr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);
    check("post_rst.q_empty", q.size(), 0);
    send(16'd7, 16'd9, 16'd1, 16'd2, W_ONE, 16'd0, 1'b0, 2'd0,
         16'd8, 16'd11, 16'd6, 16'd7, 1'b0, "post_rst", 1'b1);
    idle(5);

    // Random vs model with random ce
    rand_ce = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      send_rand(n);
      if ($urandom_range(7) == 0) idle(1);
    end
    rand_ce = 1'b0;
    for (int t = 0; t < 20 && q.size() != 0; t++) idle(1);
    check("final.drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
